// File: rtl/special_box_pkg.sv
// Shared encodings for the multi-box special glyph painter.
// Box kinds, RGB colour constants and the transaction state enum.
package special_box_pkg;

  typedef enum logic [1:0] {
    K_PLUS  = 2'b00,
    K_MINUS = 2'b01,
    K_CLEAR = 2'b10,
    K_SKIP  = 2'b11
  } box_kind_t;

  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAW,
    S_FINISH
  } state_t;

endpackage

// File: rtl/special_box_glyph.sv
// Combinational (kind, cx, cy) -> colour lookup for one box glyph.
// SPECIAL_BOX_BORDER_EN darkens the perimeter of plus/minus boxes.
module special_box_glyph
  import special_box_pkg::*;
#(
  parameter int BOX_PX = 9,
  parameter int CW     = $clog2(BOX_PX)
) (
  input  box_kind_t       kind,
  input  logic [CW-1:0]   cx,
  input  logic [CW-1:0]   cy,
  output logic [2:0]      colour
);

  localparam logic [CW-1:0] LO   = CW'(BOX_PX / 2 - 1);
  localparam logic [CW-1:0] MID  = CW'(BOX_PX / 2);
  localparam logic [CW-1:0] HI   = CW'(BOX_PX / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(BOX_PX - 1);

  logic edge_x;
  logic band_x;
  logic band_y;

  assign edge_x = (cx == '0) || (cx == LAST);
  assign band_x = (cx == LO) || (cx == MID) || (cx == HI);
  assign band_y = (cy == LO) || (cy == MID) || (cy == HI);

`ifdef SPECIAL_BOX_BORDER_EN
  logic edge_y;
  assign edge_y = (cy == '0) || (cy == LAST);
`endif

  always_comb begin
    colour = WHITE;
    if (kind == K_CLEAR)
      colour = BLACK;
`ifdef SPECIAL_BOX_BORDER_EN
    else if (edge_x || edge_y)
      colour = BLACK;
`endif
    else if (band_y)
      colour = edge_x ? WHITE
             : (kind == K_PLUS) ? GREEN : RED;
    else if (kind == K_PLUS && band_x)
      colour = GREEN;
  end

endmodule

// File: rtl/special_box_draw_multi.sv
// Draws up to NUM_BOXES glyph boxes per start/done transaction, one pixel per cycle.
// Optional dark frame on plus/minus boxes via SPECIAL_BOX_BORDER_EN.
module special_box_draw_multi
  import special_box_pkg::*;
#(
  parameter int NUM_BOXES = 4,
  parameter int COORD_W   = 5,
  parameter int LOC_W     = 9,
  parameter int CELL_PX   = 10,
  parameter int BOX_PX    = 9,
  parameter int X_ORIGIN  = 80,
  parameter int Y_ORIGIN  = 0
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [NUM_BOXES-1:0]           box_en,
  input  logic [NUM_BOXES*COORD_W-1:0]   box_x,
  input  logic [NUM_BOXES*COORD_W-1:0]   box_y,
  input  logic [NUM_BOXES*2-1:0]         box_kind,
  output logic [LOC_W-1:0]               x_loc,
  output logic [LOC_W-1:0]               y_loc,
  output logic [2:0]                     colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int CW = $clog2(BOX_PX);
  localparam int IW = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
  localparam int PW = LOC_W + 4;
  localparam logic [CW-1:0] LAST = CW'(BOX_PX - 1);
  localparam logic [IW-1:0] LAST_SLOT = IW'(NUM_BOXES - 1);

  state_t                         state;
  logic [NUM_BOXES-1:0]           en_q;
  logic [NUM_BOXES*COORD_W-1:0]   x_q;
  logic [NUM_BOXES*COORD_W-1:0]   y_q;
  logic [NUM_BOXES*2-1:0]         kind_q;
  logic [IW-1:0]                  idx;
  logic [CW-1:0]                  cx;
  logic [CW-1:0]                  cy;

  box_kind_t          kind;
  logic [COORD_W-1:0] bx;
  logic [COORD_W-1:0] by;
  logic               drawable;
  logic               last_px;
  logic               last_slot;
  logic [CW-1:0]      ncx;
  logic [CW-1:0]      ncy;
  logic [CW-1:0]      gx;
  logic [CW-1:0]      gy;
  logic [PW-1:0]      px;
  logic [PW-1:0]      py;
  logic [2:0]         glyph_colour;

  assign kind      = box_kind_t'(kind_q[{idx, 1'b0} +: 2]);
  assign bx        = x_q[idx*COORD_W +: COORD_W];
  assign by        = y_q[idx*COORD_W +: COORD_W];
  assign drawable  = en_q[idx] && (kind != K_SKIP);
  assign last_px   = (cx == LAST) && (cy == LAST);
  assign last_slot = (idx == LAST_SLOT);
  assign ncx       = (cx == LAST) ? '0 : cx + 1'b1;
  assign ncy       = (cx == LAST) ? cy + 1'b1 : cy;

  // Outputs are registered: look up the pixel about to be shown.
  assign gx = (state == S_DRAW) ? ncx : '0;
  assign gy = (state == S_DRAW) ? ncy : '0;
  assign px = PW'(X_ORIGIN) + PW'(bx) * PW'(CELL_PX) + PW'(gx);
  assign py = PW'(Y_ORIGIN) + PW'(by) * PW'(CELL_PX) + PW'(gy);

  special_box_glyph #(
    .BOX_PX (BOX_PX),
    .CW     (CW)
  ) u_glyph (
    .kind   (kind),
    .cx     (gx),
    .cy     (gy),
    .colour (glyph_colour)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      en_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      kind_q <= '0;
      idx    <= '0;
      cx     <= '0;
      cy     <= '0;
      x_loc  <= '0;
      y_loc  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      x_loc  <= '0;
      y_loc  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            en_q   <= box_en;
            x_q    <= box_x;
            y_q    <= box_y;
            kind_q <= box_kind;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (drawable) begin
            cx     <= '0;
            cy     <= '0;
            plot   <= 1'b1;
            x_loc  <= px[LOC_W-1:0];
            y_loc  <= py[LOC_W-1:0];
            colour <= glyph_colour;
            state  <= S_DRAW;
          end else if (last_slot) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAW: begin
          if (!last_px) begin
            cx     <= ncx;
            cy     <= ncy;
            plot   <= 1'b1;
            x_loc  <= px[LOC_W-1:0];
            y_loc  <= py[LOC_W-1:0];
            colour <= glyph_colour;
          end else if (last_slot) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FINISH;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_SCAN;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_special_box_draw_multi.sv
// Self-checking bench for special_box_draw_multi (default parameters).
// Table of transactions plus hand sequences for mid-run restart and reset.
module tb_special_box_draw_multi;

  localparam int NB  = 4;
  localparam int CWD = 5;
  localparam int LW  = 9;

`ifdef SPECIAL_BOX_BORDER_EN
  localparam bit BORDER = 1'b1;
  localparam int PG = 33, PK = 32, PWH = 16;
  localparam int MR = 21, MK = 32, MWH = 28;
`else
  localparam bit BORDER = 1'b0;
  localparam int PG = 39, PK = 0, PWH = 42;
  localparam int MR = 21, MK = 0, MWH = 60;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [NB-1:0]     box_en = '0;
  logic [NB*CWD-1:0] box_x = '0;
  logic [NB*CWD-1:0] box_y = '0;
  logic [NB*2-1:0]   box_kind = '0;
  logic [LW-1:0]     x_loc;
  logic [LW-1:0]     y_loc;
  logic [2:0]        colour;
  logic              plot;
  logic              busy;
  logic              done;

  special_box_draw_multi dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .box_en   (box_en),
    .box_x    (box_x),
    .box_y    (box_y),
    .box_kind (box_kind),
    .x_loc    (x_loc),
    .y_loc    (y_loc),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [2:0] pix [int];

  typedef struct {
    string         name;
    logic [NB-1:0] en;
    logic [19:0]   bx;
    logic [19:0]   by;
    logic [7:0]    kind;
    int            np, nm, nc;
    int            fx, fy, lx, ly;
    bit            perturb;
  } vec_t;

  typedef struct {
    int v;
    int x;
    int y;
    int cb;
    int cd;
  } probe_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [19:0] p5(input int a, b, c, d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [7:0] p2(input int a, b, c, d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  task automatic run(input vec_t v);
    int cyc, plots, busy_n, dones, lat;
    int g, r, w, k, other, fx, fy, lx, ly, n;
    bit pert;
    cyc = 0; plots = 0; busy_n = 0; dones = 0; lat = -1;
    g = 0; r = 0; w = 0; k = 0; other = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; pert = 1'b0;
    pix.delete();
    @(negedge clk);
    box_en = v.en; box_x = v.bx; box_y = v.by; box_kind = v.kind;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (plot) begin
        pix[int'(x_loc) * 512 + int'(y_loc)] = colour;
        if (plots == 0) begin fx = x_loc; fy = y_loc; end
        lx = x_loc; ly = y_loc;
        plots++;
        case (colour)
          3'b010:  g++;
          3'b100:  r++;
          3'b111:  w++;
          3'b000:  k++;
          default: other++;
        endcase
      end
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (lat < 0) begin
          lat = cyc;
          chk({v.name, " busy_at_done"}, int'(busy), 0);
        end
      end
      if (v.perturb && plots == 20 && !pert) begin
        pert = 1'b1;
        box_x = p5(7, 9, 11, 13);
        box_kind = p2(1, 1, 1, 1);
        box_en = 4'b1111;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (lat >= 0 && cyc >= lat + 3) break;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    n = v.np + v.nm + v.nc;
    chk({v.name, " latency"}, lat, NB + 1 + n * 81);
    chk({v.name, " busy_cycles"}, busy_n, NB + n * 81);
    chk({v.name, " done_count"}, dones, 1);
    chk({v.name, " plots"}, plots, n * 81);
    chk({v.name, " unique_px"}, pix.num(), n * 81);
    chk({v.name, " green"}, g, v.np * PG);
    chk({v.name, " red"}, r, v.nm * MR);
    chk({v.name, " white"}, w, v.np * PWH + v.nm * MWH);
    chk({v.name, " black"}, k, v.np * PK + v.nm * MK + v.nc * 81);
    chk({v.name, " other"}, other, 0);
    if (n > 0) begin
      chk({v.name, " first_x"}, fx, v.fx);
      chk({v.name, " first_y"}, fy, v.fy);
      chk({v.name, " last_x"}, lx, v.lx);
      chk({v.name, " last_y"}, ly, v.ly);
    end
  endtask

  task automatic probes(input int vi, input probe_t pt[$]);
    foreach (pt[i]) begin
      if (pt[i].v == vi) begin
        int key;
        key = pt[i].x * 512 + pt[i].y;
        if (pix.exists(key))
          chk($sformatf("px%0d(%0d,%0d)", vi, pt[i].x, pt[i].y),
              int'(pix[key]), BORDER ? pt[i].cd : pt[i].cb);
        else
          chk($sformatf("px%0d(%0d,%0d) missing", vi, pt[i].x, pt[i].y), 0, 1);
      end
    end
  endtask

  initial begin
    vec_t   vt[7];
    probe_t pt[$];
    int     plots;
    int     guard;

    vt[0] = '{"plus00", 4'b0001, p5(0,0,0,0), p5(0,0,0,0), p2(0,0,0,0),
              1, 0, 0, 80, 0, 88, 8, 1'b0};
    vt[1] = '{"plus_minus", 4'b0101, p5(2,9,5,0), p5(3,9,1,0), p2(0,0,1,0),
              1, 1, 0, 100, 30, 138, 18, 1'b0};
    vt[2] = '{"none", 4'b0000, p5(1,2,3,4), p5(1,2,3,4), p2(0,1,0,1),
              0, 0, 0, 0, 0, 0, 0, 1'b0};
    vt[3] = '{"skip_clear", 4'b0011, p5(0,1,0,0), p5(0,1,0,0), p2(3,2,0,0),
              0, 0, 1, 90, 10, 98, 18, 1'b0};
    vt[4] = '{"mixed4", 4'b1111, p5(0,1,2,3), p5(0,0,0,0), p2(0,1,2,3),
              1, 1, 1, 80, 0, 108, 8, 1'b0};
    vt[5] = '{"slot3_corner", 4'b1000, p5(0,0,0,31), p5(0,0,0,31), p2(0,0,0,1),
              0, 1, 0, 390, 310, 398, 318, 1'b0};
    vt[6] = '{"restart_ignored", 4'b0001, p5(0,0,0,0), p5(0,0,0,0), p2(0,0,0,0),
              1, 0, 0, 80, 0, 88, 8, 1'b1};

    pt.push_back('{0, 80, 0, 7, 0});
    pt.push_back('{0, 84, 0, 2, 0});
    pt.push_back('{0, 84, 4, 2, 2});
    pt.push_back('{0, 80, 4, 7, 0});
    pt.push_back('{0, 88, 8, 7, 0});
    pt.push_back('{0, 83, 2, 2, 2});
    pt.push_back('{0, 82, 2, 7, 7});
    pt.push_back('{1, 100, 30, 7, 0});
    pt.push_back('{1, 104, 34, 2, 2});
    pt.push_back('{1, 104, 31, 2, 2});
    pt.push_back('{1, 134, 14, 4, 4});
    pt.push_back('{1, 134, 10, 7, 0});
    pt.push_back('{1, 131, 11, 7, 7});
    pt.push_back('{1, 130, 14, 7, 0});
    pt.push_back('{3, 90, 10, 0, 0});
    pt.push_back('{3, 94, 14, 0, 0});
    pt.push_back('{3, 98, 18, 0, 0});
    pt.push_back('{4, 84, 4, 2, 2});
    pt.push_back('{4, 94, 4, 4, 4});
    pt.push_back('{4, 104, 4, 0, 0});
    pt.push_back('{5, 394, 314, 4, 4});
    pt.push_back('{5, 398, 318, 7, 0});
    pt.push_back('{6, 80, 0, 7, 0});
    pt.push_back('{6, 84, 4, 2, 2});
    pt.push_back('{6, 88, 8, 7, 0});

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset plot", int'(plot), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset x_loc", int'(x_loc), 0);
    chk("reset y_loc", int'(y_loc), 0);
    chk("reset colour", int'(colour), 0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(vt[i]);
      probes(i, pt);
    end

    // Reset at pixel 40 of a live transaction.
    @(negedge clk);
    box_en = vt[0].en; box_x = vt[0].bx; box_y = vt[0].by; box_kind = vt[0].kind;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plots = 0;
    guard = 0;
    while (plots < 40 && guard < 500) begin
      if (plot) plots++;
      if (plots < 40) @(negedge clk);
      guard++;
    end
    chk("mid_reset reached_px40", plots, 40);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset plot", int'(plot), 0);
    chk("mid_reset busy", int'(busy), 0);
    chk("mid_reset x_loc", int'(x_loc), 0);
    chk("mid_reset y_loc", int'(y_loc), 0);
    chk("mid_reset done", int'(done), 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset idle_plot", int'(plot), 0);
    vt[0].name = "after_reset";
    run(vt[0]);
    probes(0, pt);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
